pll_lock_seq: RTL
=================

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 27, giving the PLL reset pulse width in clk cycles (1 us at 27 MHz).
REQ-002 The block SHALL have parameter LOCK_STABLE, default 2700, giving the number of consecutive clk cycles lock must stay high before release.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 270000, giving the clk cycles allowed in WAIT_LOCK before a retry.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, giving the number of timeout retries allowed before FAIL (range 0..3).
REQ-005 The block SHALL have port clk, input, 1 bit: the 27 MHz board clock, which is also the PLL reference.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the only reset, asynchronous and active-low.
REQ-007 The block SHALL have port pll_lock, input, 1 bit: the rPLL LOCK output, asynchronous to clk.
REQ-008 The block SHALL have port relock_req, input, 1 bit: a single-cycle pulse requesting a full PLL restart.
REQ-009 The block SHALL have port pll_reset, output, 1 bit: drives rPLL RESET, active-high.
REQ-010 The block SHALL have port sys_rst_n, output, 1 bit: the active-low reset for downstream logic in the PLL clock domain (LCD timing).
REQ-011 The block SHALL have port ready, output, 1 bit: high only in the RUN state.
REQ-012 The block SHALL have port fail, output, 1 bit: high only in the FAIL state.
REQ-013 The block SHALL have port retry_cnt, output, 2 bits: the number of timeout retries taken in the current attempt.

Function
REQ-014 pll_lock SHALL pass through a 2-flop synchronizer to form lock_s; only lock_s is used.
REQ-015 The FSM states SHALL be RESET, WAIT_LOCK, STABLE, RUN and FAIL, with one shared cycle counter of 20 bits.
REQ-016 In RESET, pll_reset SHALL be 1 for exactly RST_CYCLES cycles; the FSM then enters WAIT_LOCK, the counter clears, and lock_s is ignored.
REQ-017 In WAIT_LOCK, pll_reset SHALL be 0.
- If lock_s=1: go to STABLE and clear the counter.
- Else, on the counter reaching LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY go to FAIL, otherwise increment retry_cnt and go to RESET.
REQ-018 In STABLE, if lock_s=0 the FSM SHALL return to WAIT_LOCK with the counter cleared, so the timeout restarts from 0.
REQ-019 In STABLE, after LOCK_STABLE consecutive cycles with lock_s=1, the FSM SHALL go to RUN.
REQ-020 In RUN, sys_rst_n=1 and ready=1; lock_s=0 or relock_req=1 (alone or simultaneous) SHALL send the FSM to RESET with retry_cnt cleared.
REQ-021 In FAIL, pll_reset SHALL be held at 1 and fail=1; relock_req SHALL go to RESET with retry_cnt cleared.
REQ-022 relock_req SHALL be ignored in RESET, WAIT_LOCK and STABLE.
REQ-023 All outputs SHALL be registered and SHALL change on the same edge as the state transition.
REQ-024 sys_rst_n SHALL be 0 in every state except RUN, and SHALL fall on the first edge after RUN is left.
REQ-025 Release latency: with pll_lock held high and first sampled at edge E in WAIT_LOCK, ready and sys_rst_n SHALL rise at edge E+2+LOCK_STABLE.

Reset
REQ-026 While rst_n=0, the block SHALL hold state=RESET, counter=0, synchronizer=0, pll_reset=1, sys_rst_n=0, ready=0, fail=0 and retry_cnt=0.
REQ-027 After rst_n rises, the block SHALL spend RST_CYCLES cycles in RESET.
REQ-028 rst_n asserted in any state, including mid-count, SHALL force the REQ-026 values immediately.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2)
REQ-029 Nominal lock: release rst_n, raise pll_lock 10 cycles later -> pll_reset high for 4 cycles, then ready and sys_rst_n rise 10 edges after lock is first sampled; retry_cnt=0.
REQ-030 Glitch in STABLE: drop pll_lock for 1 cycle mid-STABLE -> return to WAIT_LOCK, stable count restarts, and ready rises 10 edges after lock is re-sampled high.
REQ-031 No lock: pll_lock held 0 -> 3 reset pulses of 4 cycles each spaced by 32-cycle waits, retry_cnt goes 0->1->2, then FAIL with fail=1 and pll_reset=1; relock_req then gives a 4-cycle pulse with retry_cnt=0.
REQ-032 Loss in RUN: drop pll_lock while ready=1 -> sys_rst_n=0 and ready=0 three edges after the drop, followed by a 4-cycle pll_reset pulse.
REQ-033 relock_req in RUN -> sys_rst_n falls on the next edge and pll_reset is high for 4 cycles; relock_req pulsed in WAIT_LOCK -> no effect.
REQ-034 Reset mid-operation: assert rst_n in STABLE -> all outputs take reset values within the same cycle; after release the full sequence repeats.

Source files
------------

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: rPLL reset/lock sequencer with stable-lock qualification,
// timeout retries, failure latch and a registered downstream reset.
//
// Parameters:
//   RST_CYCLES   - pll_reset pulse width in clk cycles
//   LOCK_STABLE  - consecutive locked cycles required before release
//   LOCK_TIMEOUT - cycles allowed waiting for lock before a retry
//   MAX_RETRY    - timeout retries allowed before giving up (0..3)
//
// Ports:
//   clk        - board clock, also the PLL reference
//   rst_n      - asynchronous active-low reset
//   pll_lock   - rPLL LOCK, asynchronous to clk
//   relock_req - single-cycle request for a full PLL restart
//   pll_reset  - rPLL RESET, active-high
//   sys_rst_n  - active-low reset for logic in the PLL clock domain
//   ready      - high only while running with a qualified lock
//   fail       - high only after all retries are exhausted
//   retry_cnt  - timeout retries taken in the current attempt

`timescale 1ns/1ps

module pll_lock_seq #(
    parameter int RST_CYCLES   = 27,
    parameter int LOCK_STABLE  = 2700,
    parameter int LOCK_TIMEOUT = 270000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    localparam int CW = 20;

    // Terminal counts: the counter starts at zero on state entry, so the
    // last cycle of each timed state is the count minus one.
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]    RET_MAX  = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [1:0]      retry_q;
    logic [1:0]      retry_d;
    logic [1:0]      sync_q;
    logic            lock_s;

    logic            pll_reset_q;
    logic            pll_reset_d;
    logic            sys_rst_n_q;
    logic            sys_rst_n_d;
    logic            ready_q;
    logic            ready_d;
    logic            fail_q;
    logic            fail_d;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    assign lock_s = sync_q[1];

    // Next-state, shared counter and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        unique case (state_q)
            S_RESET: begin
                // Lock is meaningless while the PLL is held in reset.
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RET_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_RESET;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STABLE: begin
                // Any dropout restarts the lock wait with a fresh timeout.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                if (!lock_s || relock_req) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end

            S_FAIL: begin
                if (relock_req) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = S_RESET;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies
    // switch on the same edge as the state register.
    always_comb begin
        pll_reset_d = (state_d == S_RESET) || (state_d == S_FAIL);
        sys_rst_n_d = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule
